// File: rtl/fmau_acc_pkg.sv
// fmau_acc_pkg: shared state encoding, default widths and signed range helpers for FMAU accumulate stages
package fmau_acc_pkg;
  typedef enum logic [1:0] {IDLE, ACCUM, HOLD} state_t;
  localparam int PROD_W = 16;
  localparam int ACC_W = 24;
  localparam int CNT_W = 8;
  function automatic logic [63:0] smax(int w);
    return (64'd1 << (w - 1)) - 64'd1;
  endfunction
  function automatic logic [63:0] smin(int w);
    return ~smax(w);
  endfunction
endpackage

// File: rtl/sat_signed_add.sv
// sat_signed_add: sign-extending add of a narrow operand into a wide one, saturating to the wide signed range
module sat_signed_add
  import fmau_acc_pkg::*;
#(
  parameter int ACC_W = 24,
  parameter int PROD_W = 16
) (
  input  logic [ACC_W-1:0]  a,
  input  logic [PROD_W-1:0] b,
  output logic [ACC_W-1:0]  sum,
  output logic              ovf
);
  logic [ACC_W:0] s;
  assign s = {a[ACC_W-1], a} + {{(ACC_W + 1 - PROD_W){b[PROD_W-1]}}, b};
  // the extra top bit disagrees with the sign bit exactly when the result left the ACC_W range
  assign ovf = s[ACC_W] ^ s[ACC_W-1];
  assign sum = ovf ? (s[ACC_W] ? ACC_W'(smin(ACC_W)) : ACC_W'(smax(ACC_W))) : s[ACC_W-1:0];
endmodule

// File: rtl/signed_product_accumulator.sv
// signed_product_accumulator: sums a packet of signed products with saturation and hands off sum, count and overflow
module signed_product_accumulator
  import fmau_acc_pkg::*;
#(
  parameter int PROD_W = 16,
  parameter int ACC_W = 24,
  parameter int CNT_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [PROD_W-1:0] in_prod,
  input  logic              in_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ACC_W-1:0]  out_acc,
  output logic [CNT_W-1:0]  out_count,
  output logic              out_ovf
);
  state_t state;
  logic [ACC_W-1:0] acc, sum;
  logic [CNT_W-1:0] count;
  logic ovf, add_ovf;
  sat_signed_add #(.ACC_W(ACC_W), .PROD_W(PROD_W)) u_add (
    .a(acc), .b(in_prod), .sum(sum), .ovf(add_ovf)
  );
  assign in_ready = state != HOLD;
  assign out_acc = acc;
  assign out_count = count;
  assign out_ovf = ovf;
  // beat accept and output handshake are exclusive because in_ready is low in HOLD
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      acc <= '0;
      count <= '0;
      ovf <= 1'b0;
      out_valid <= 1'b0;
    end else if (in_valid && in_ready) begin
      acc <= sum;
      ovf <= ovf | add_ovf;
      count <= &count ? count : count + CNT_W'(1);
      state <= in_last ? HOLD : ACCUM;
      out_valid <= in_last;
    end else if (out_valid && out_ready) begin
      acc <= '0;
      count <= '0;
      ovf <= 1'b0;
      out_valid <= 1'b0;
      state <= IDLE;
    end
  end
endmodule

// File: tb/tb_signed_product_accumulator.sv
// tb_signed_product_accumulator: directed vectors with hand-computed results for the packet accumulator
module tb_signed_product_accumulator;
  logic clk = 1'b0, rst_n = 1'b0;
  logic in_valid = 1'b0, in_last = 1'b0, out_ready = 1'b0;
  logic [15:0] in_prod = '0;
  logic in_ready, out_valid, out_ovf;
  logic [23:0] out_acc;
  logic [7:0] out_count;
  int total = 0, bad = 0;
  always #5 clk = ~clk;
  signed_product_accumulator dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_prod(in_prod), .in_last(in_last), .out_valid(out_valid), .out_ready(out_ready),
    .out_acc(out_acc), .out_count(out_count), .out_ovf(out_ovf)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic beat(input logic [15:0] p, input logic l);
    in_valid = 1'b1;
    in_prod = p;
    in_last = l;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_last = 1'b0;
  endtask
  task automatic drain();
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    chk("drain_valid", out_valid, 0);
    chk("drain_ready", in_ready, 1);
  endtask
  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready", in_ready, 1);
    chk("rst_valid", out_valid, 0);
    chk("rst_acc", out_acc, 0);
    chk("rst_cnt", out_count, 0);
    chk("rst_ovf", out_ovf, 0);
    rst_n = 1'b1;
    out_ready = 1'b1;
    beat(16'h0005, 0);
    beat(16'hFFFD, 0);
    beat(16'h0010, 1);
    chk("t1_valid", out_valid, 1);
    chk("t1_acc", out_acc, 24'h000012);
    chk("t1_cnt", out_count, 3);
    chk("t1_ovf", out_ovf, 0);
    chk("t1_busy", in_ready, 0);
    @(posedge clk);
    #1;
    chk("t1_ready", in_ready, 1);
    chk("t1_done", out_valid, 0);
    out_ready = 1'b0;
    beat(16'h8000, 1);
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      in_prod = 16'h1234;
      in_last = 1'b1;
      @(posedge clk);
      #1;
      chk("t2_valid", out_valid, 1);
      chk("t2_acc", out_acc, 24'hFF8000);
      chk("t2_cnt", out_count, 1);
      chk("t2_ready", in_ready, 0);
    end
    in_valid = 1'b0;
    in_last = 1'b0;
    drain();
    for (int i = 0; i < 257; i++) beat(16'h7FFF, 0);
    chk("t3_sat_acc", out_acc, 24'h7FFFFF);
    chk("t3_sat_ovf", out_ovf, 1);
    for (int i = 257; i < 299; i++) beat(16'h7FFF, 0);
    beat(16'h7FFF, 1);
    chk("t3_acc", out_acc, 24'h7FFFFF);
    chk("t3_cnt", out_count, 8'hFF);
    chk("t3_ovf", out_ovf, 1);
    drain();
    beat(16'h0001, 1);
    chk("t3n_acc", out_acc, 1);
    chk("t3n_ovf", out_ovf, 0);
    chk("t3n_cnt", out_count, 1);
    drain();
    for (int i = 0; i < 299; i++) beat(16'h8000, 0);
    beat(16'h8000, 1);
    chk("t4_acc", out_acc, 24'h800000);
    chk("t4_ovf", out_ovf, 1);
    chk("t4_cnt", out_count, 8'hFF);
    drain();
    beat(16'h0100, 0);
    beat(16'h0100, 0);
    chk("t5_mid_acc", out_acc, 24'h000200);
    #2 rst_n = 1'b0;
    #1;
    chk("t5_rst_ready", in_ready, 1);
    chk("t5_rst_valid", out_valid, 0);
    chk("t5_rst_acc", out_acc, 0);
    chk("t5_rst_cnt", out_count, 0);
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;
    beat(16'h0002, 1);
    chk("t5_acc", out_acc, 2);
    chk("t5_cnt", out_count, 1);
    drain();
    beat(16'h0003, 0);
    in_prod = 16'h7777;
    in_last = 1'b1;
    repeat (2) begin
      @(posedge clk);
      #1;
      chk("t6_gap_acc", out_acc, 3);
      chk("t6_gap_cnt", out_count, 1);
    end
    beat(16'hFFFF, 1);
    chk("t6_valid", out_valid, 1);
    chk("t6_acc", out_acc, 2);
    chk("t6_cnt", out_count, 2);
    drain();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
